tlb_search_ctrl: RTL

Sequential TLB lookup controller for the MMU. It arbitrates between the instruction-fetch and data-access requesters and scans the TLB entry array one entry per cycle through a synchronous read port. Each entry is judged for context match (V/TS/TID/EPN) and access permission. It returns a single registered response: hit with entry index, ISI/DSI permission fault, or ITLB/DTLB miss.

---
 rtl/mmu_pkg.sv | 20 ++
 rtl/tlb_entry_compare.sv | 23 ++
 rtl/tlb_search_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU constants, access kinds and permission-bit selection.
package mmu_pkg;
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] DSI      = 5'd2;
  localparam logic [4:0] ISI      = 5'd3;
  localparam logic [4:0] DTLB     = 5'd13;
  localparam logic [4:0] ITLB     = 5'd14;
  localparam logic [2:0] PERM_SR = 3'd0;
  localparam logic [2:0] PERM_UR = 3'd1;
  localparam logic [2:0] PERM_SW = 3'd2;
  localparam logic [2:0] PERM_UW = 3'd3;
  localparam logic [2:0] PERM_SX = 3'd4;
  localparam logic [2:0] PERM_UX = 3'd5;
  typedef enum logic [1:0] {FETCH, LOAD, STORE} access_e;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;
  function automatic logic [2:0] perm_pos(input access_e kind, input logic pr);
    return kind == FETCH ? (pr ? PERM_UX : PERM_SX) :
           kind == STORE ? (pr ? PERM_UW : PERM_SW) : (pr ? PERM_UR : PERM_SR);
  endfunction
endpackage

// File: rtl/tlb_entry_compare.sv
// tlb_entry_compare: judges one TLB entry against the latched lookup context.
module tlb_entry_compare
  import mmu_pkg::*;
(
  input  access_e     kind_i,
  input  logic        as_i,
  input  logic        pr_i,
  input  logic [7:0]  pid0_i,
  input  logic [7:0]  pid1_i,
  input  logic [7:0]  pid2_i,
  input  logic [31:0] ea_i,
  input  logic        v_i,
  input  logic        ts_i,
  input  logic [7:0]  tid_i,
  input  logic [31:0] epn_i,
  input  logic [5:0]  permis_i,
  output logic        match_o,
  output logic        perm_ok_o
);
  assign match_o = v_i && (ts_i == as_i) && epn_i == ea_i &&
                   (tid_i == 8'd0 || tid_i == pid0_i || tid_i == pid1_i || tid_i == pid2_i);
  assign perm_ok_o = permis_i[perm_pos(kind_i, pr_i)];
endmodule

// File: rtl/tlb_search_ctrl.sv
// tlb_search_ctrl: arbitrates I/D lookups and scans the TLB one entry per cycle,
// returning a registered hit / permission-fault / miss response.
module tlb_search_ctrl
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       PID0,
  input  logic [7:0]       PID1,
  input  logic [7:0]       PID2,
  input  logic             MSR_PR,
  input  logic             MSR_IS,
  input  logic             MSR_DS,
  input  logic             I_req,
  input  logic [31:0]      I_EA,
  output logic             I_ack,
  input  logic             D_req,
  input  logic [31:0]      D_EA,
  input  logic             D_store,
  output logic             D_ack,
  output logic             Tlb_rd_en,
  output logic [IDX_W-1:0] Tlb_rd_idx,
  input  logic             TLB_entry_V,
  input  logic             TLB_entry_TS,
  input  logic [7:0]       TLB_entry_TID,
  input  logic [31:0]      TLB_entry_EPN,
  input  logic [5:0]       TLB_entry_PERMIS,
  input  logic             Tlb_wr,
  output logic             Rsp_valid,
  output logic             Rsp_port,
  output logic             Rsp_hit,
  output logic [IDX_W-1:0] Rsp_index,
  output logic [4:0]       Rsp_exception
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);
  state_e state_q, state_d;
  access_e kind_q, kind_d;
  logic prio_d_q, prio_d_d, port_q, port_d, as_q, as_d, pr_q, pr_d;
  logic [31:0] ea_q, ea_d;
  logic [23:0] pid_q, pid_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, cmp_idx_q;
  logic cmp_vld_q, cmp_vld_d, i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic rsp_port_q, rsp_port_d, rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic [4:0] rsp_exc_q, rsp_exc_d;
  logic pick_d, match, perm_ok, done;
  tlb_entry_compare u_cmp (
    .kind_i(kind_q), .as_i(as_q), .pr_i(pr_q),
    .pid0_i(pid_q[23:16]), .pid1_i(pid_q[15:8]), .pid2_i(pid_q[7:0]), .ea_i(ea_q),
    .v_i(TLB_entry_V), .ts_i(TLB_entry_TS), .tid_i(TLB_entry_TID), .epn_i(TLB_entry_EPN),
    .permis_i(TLB_entry_PERMIS), .match_o(match), .perm_ok_o(perm_ok)
  );
  // prio_d_q set means D wins a tie, i.e. I was granted last
  assign pick_d = D_req && (!I_req || prio_d_q);
  assign done = cmp_vld_q && (match || cmp_idx_q == LAST);
  always_comb begin
    state_d = state_q;
    prio_d_d = prio_d_q;
    port_d = port_q;
    kind_d = kind_q;
    ea_d = ea_q;
    as_d = as_q;
    pr_d = pr_q;
    pid_d = pid_q;
    cnt_d = cnt_q;
    cmp_vld_d = 1'b0;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    rsp_port_d = rsp_port_q;
    rsp_hit_d = rsp_hit_q;
    rsp_idx_d = rsp_idx_q;
    rsp_exc_d = rsp_exc_q;
    case (state_q)
      IDLE: if (I_req || D_req) begin
        state_d = SCAN;
        prio_d_d = !pick_d;
        port_d = pick_d;
        kind_d = pick_d ? (D_store ? STORE : LOAD) : FETCH;
        ea_d = pick_d ? D_EA : I_EA;
        as_d = pick_d ? MSR_DS : MSR_IS;
        pr_d = MSR_PR;
        pid_d = {PID0, PID1, PID2};
        i_ack_d = !pick_d;
        d_ack_d = pick_d;
        cnt_d = '0;
      end
      SCAN: begin
        cnt_d = Tlb_wr ? '0 : (cnt_q == LAST ? cnt_q : cnt_q + 1'b1);
        cmp_vld_d = !Tlb_wr;
        if (!Tlb_wr && done) begin
          state_d = RESP;
          rsp_port_d = port_q;
          rsp_hit_d = match && perm_ok;
          rsp_idx_d = match ? cmp_idx_q : '0;
          rsp_exc_d = match ? (perm_ok ? EXC_NONE : (port_q ? DSI : ISI)) : (port_q ? DTLB : ITLB);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_d_q <= 1'b0;
      cnt_q <= '0;
      cmp_vld_q <= 1'b0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      rsp_port_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_idx_q <= '0;
      rsp_exc_q <= '0;
    end else begin
      state_q <= state_d;
      prio_d_q <= prio_d_d;
      cnt_q <= cnt_d;
      cmp_vld_q <= cmp_vld_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      rsp_port_q <= rsp_port_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_exc_q <= rsp_exc_d;
    end
    port_q <= port_d;
    kind_q <= kind_d;
    ea_q <= ea_d;
    as_q <= as_d;
    pr_q <= pr_d;
    pid_q <= pid_d;
    cmp_idx_q <= cnt_q;
  end
  assign I_ack = i_ack_q;
  assign D_ack = d_ack_q;
  assign Tlb_rd_en = state_q == SCAN;
  assign Tlb_rd_idx = cnt_q;
  assign Rsp_valid = state_q == RESP;
  assign Rsp_port = rsp_port_q;
  assign Rsp_hit = rsp_hit_q;
  assign Rsp_index = rsp_idx_q;
  assign Rsp_exception = rsp_exc_q;
endmodule
